// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS9 constants, checker state encoding and counter widths
package prbs_pkg;
    localparam int PRBS_W    = 9;
    localparam int TAP_HI    = 8;
    localparam int TAP_LO    = 4;
    localparam int FILL_W    = 4;
    localparam int ERR_CNT_W = 16;
    localparam int BIT_CNT_W = 32;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/prbs9_step.sv
// prbs9_step: one PRBS9 (x^9+x^5+1) step, shared by generator and checker
// Ports: i_sr current register; o_bit next bit sr[8]^sr[4]; o_sr register after shifting o_bit in at bit 0
module prbs9_step
    import prbs_pkg::*;
(
    input  logic [PRBS_W-1:0] i_sr,
    output logic              o_bit,
    output logic [PRBS_W-1:0] o_sr
);
    assign o_bit = i_sr[TAP_HI] ^ i_sr[TAP_LO];
    assign o_sr  = {i_sr[PRBS_W-2:0], o_bit};
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: PRBS9 receive checker with SEARCH/VERIFY/LOCKED acquisition and error counting
// Ports: clock; i_reset sync active-low; i_enable bit strobe; i_enb_rx rx enable; i_bit serial data;
//        o_lock locked flag; o_err error pulse; o_err_count / o_bit_count saturating counters
// Option: PRBS_CHK_RELOCK_EN drops lock after ERR_THR errors within one WIN_LEN-bit window
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THR = 16,
    parameter int ERR_THR  = 8,
    parameter int WIN_LEN  = 64
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_enb_rx,
    input  logic                 i_bit,
    output logic                 o_lock,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [BIT_CNT_W-1:0] o_bit_count
);
    localparam int MW = $clog2(LOCK_THR) + 1;
    if (LOCK_THR < 1 || ERR_THR < 1 || WIN_LEN < 2 || (WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_cfg
        $error("prbs_checker: invalid LOCK_THR/ERR_THR/WIN_LEN");
    end
    state_t            r_state;
    logic [PRBS_W-1:0] r_sr;
    logic [FILL_W-1:0] r_fill;
    logic [MW-1:0]     r_match;
    logic              w_acc;
    logic              w_exp;
    logic              w_miss;
    logic [PRBS_W-1:0] w_sr_gen;
    logic [PRBS_W-1:0] w_sr_fill;
    prbs9_step u_step (
        .i_sr  (r_sr),
        .o_bit (w_exp),
        .o_sr  (w_sr_gen)
    );
    assign w_acc     = i_enable & i_enb_rx;
    assign w_miss    = i_bit ^ w_exp;
    assign w_sr_fill = {r_sr[PRBS_W-2:0], i_bit};
`ifdef PRBS_CHK_RELOCK_EN
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(ERR_THR) + 1;
    logic [WW-1:0] r_win;
    logic [EW-1:0] r_win_err;
    logic [EW-1:0] w_win_err_n;
    // the current bit's error counts in the window it completes, before any wrap clear
    assign w_win_err_n = r_win_err + EW'(w_miss);
`endif
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state     <= SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            o_lock      <= 1'b0;
            o_err       <= 1'b0;
            o_err_count <= '0;
            o_bit_count <= '0;
`ifdef PRBS_CHK_RELOCK_EN
            r_win       <= '0;
            r_win_err   <= '0;
`endif
        end else begin
            o_err <= 1'b0;
            if (w_acc) begin
                case (r_state)
                    SEARCH: begin
                        // an all-zero fill is the PRBS lock-up state, so refill instead
                        r_sr   <= w_sr_fill;
                        r_fill <= (r_fill == FILL_W'(PRBS_W - 1)) ? '0 : r_fill + FILL_W'(1);
                        if (r_fill == FILL_W'(PRBS_W - 1) && |w_sr_fill) begin
                            r_state <= VERIFY;
                            r_match <= '0;
                        end
                    end
                    VERIFY: begin
                        r_sr <= w_sr_gen;
                        if (w_miss) begin
                            r_state <= SEARCH;
                            r_fill  <= '0;
                            r_match <= '0;
                        end else if (r_match == MW'(LOCK_THR - 1)) begin
                            r_state <= LOCKED;
                            r_match <= '0;
                            o_lock  <= 1'b1;
`ifdef PRBS_CHK_RELOCK_EN
                            r_win     <= '0;
                            r_win_err <= '0;
`endif
                        end else begin
                            r_match <= r_match + MW'(1);
                        end
                    end
                    default: begin
                        r_sr  <= w_sr_gen;
                        o_err <= w_miss;
                        if (w_miss && o_err_count != '1)
                            o_err_count <= o_err_count + ERR_CNT_W'(1);
                        if (o_bit_count != '1)
                            o_bit_count <= o_bit_count + BIT_CNT_W'(1);
`ifdef PRBS_CHK_RELOCK_EN
                        r_win     <= r_win + WW'(1);
                        r_win_err <= (r_win == WW'(WIN_LEN - 1)) ? '0 : w_win_err_n;
                        if (w_miss && w_win_err_n >= EW'(ERR_THR)) begin
                            r_state <= SEARCH;
                            r_fill  <= '0;
                            o_lock  <= 1'b0;
                        end
`endif
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker driven by a PRBS9 generator
module tb_prbs_checker;
    import prbs_pkg::*;
    typedef struct packed {
        logic        lock;
        logic        err;
        logic [15:0] ec;
        logic [31:0] bc;
    } exp_t;
    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_enb_rx = 1'b1;
    logic        i_bit = 1'b0;
    logic        o_lock;
    logic        o_err;
    logic [15:0] o_err_count;
    logic [31:0] o_bit_count;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [8:0]  gen = 9'h1AA;
    int          m_n;
    int          m_wpos;
    int          m_werr;
    logic        m_lock;
    logic [15:0] m_errc;
    logic [31:0] m_bitc;
    prbs_checker dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_enb_rx    (i_enb_rx),
        .i_bit       (i_bit),
        .o_lock      (o_lock),
        .o_err       (o_err),
        .o_err_count (o_err_count),
        .o_bit_count (o_bit_count)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("lock", 64'(o_lock), 64'(e.lock));
            check("err", 64'(o_err), 64'(e.err));
            check("err_count", 64'(o_err_count), 64'(e.ec));
            check("bit_count", 64'(o_bit_count), 64'(e.bc));
        end
    endtask
    task automatic push(input logic err);
        sb.push_back('{lock: m_lock, err: err, ec: m_errc, bc: m_bitc});
    endtask
    task automatic do_reset();
        i_reset = 1'b0;
        i_enable = 1'b1;
        i_enb_rx = 1'b1;
        m_n = 0;
        m_wpos = 0;
        m_werr = 0;
        m_lock = 1'b0;
        m_errc = '0;
        m_bitc = '0;
        push(1'b0);
        tick();
        i_reset = 1'b1;
    endtask
    task automatic send(input logic inj);
        logic e_err;
        e_err = 1'b0;
        i_enable = 1'b1;
        i_enb_rx = 1'b1;
        i_bit = gen[8] ^ inj;
        gen = {gen[7:0], gen[8] ^ gen[4]};
        if (m_lock) begin
            m_bitc++;
            if (inj) begin
                e_err = 1'b1;
                m_errc++;
            end
`ifdef PRBS_CHK_RELOCK_EN
            if (inj) m_werr++;
            if (m_werr >= 8) begin
                m_lock = 1'b0;
                m_n = 0;
            end
            if (m_wpos == 63) m_werr = 0;
            m_wpos = (m_wpos + 1) % 64;
`endif
        end else begin
            m_n++;
            if (m_n == 25) begin
                m_lock = 1'b1;
                m_wpos = 0;
                m_werr = 0;
            end
        end
        push(e_err);
        tick();
    endtask
    task automatic pause();
        i_enb_rx = 1'b0;
        i_bit = 1'($urandom);
        push(1'b0);
        tick();
        i_enb_rx = 1'b1;
    endtask
    task automatic zero();
        i_bit = 1'b0;
        push(1'b0);
        tick();
    endtask
    initial begin
        do_reset();
        do_reset();
        for (int i = 0; i < 200; i++) zero();
        check("state_search", 64'(dut.r_state), 64'(SEARCH));
        do_reset();
        for (int i = 0; i < 1000; i++) send(1'b0);
        for (int i = 0; i < 20; i++) send(1'b0);
        send(1'b1);
        for (int i = 0; i < 30; i++) send(1'b0);
        for (int i = 0; i < 5; i++) send(1'b0);
        for (int i = 0; i < 10; i++) pause();
        for (int i = 0; i < 20; i++) send(1'b0);
        do_reset();
        for (int i = 0; i < 40; i++) send(1'b0);
        do_reset();
        for (int i = 0; i < 30; i++) send(1'b0);
        for (int k = 0; k < 8; k++) begin
            send(1'b1);
            send(1'b0);
            send(1'b0);
        end
        for (int i = 0; i < 40; i++) send(1'b0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_THR, default 16: consecutive matching bits required to declare lock.
REQ-002 SHALL have parameter ERR_THR, default 8: errors within one window that declare loss of lock.
REQ-003 SHALL have parameter WIN_LEN, default 64: error-window length in accepted bits (power of two).
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_enable  input  1  bit-rate strobe.
REQ-007 SHALL have port i_enb_rx  input  1  receive path enable.
REQ-008 SHALL have port i_bit  input  1  received serial PRBS9 bit.
REQ-009 SHALL have port o_lock  output  1  high while the state is LOCKED.
REQ-010 SHALL have port o_err  output  1  one-cycle pulse per detected bit error.
REQ-011 SHALL have port o_err_count  output  16  saturating count of errors since reset.
REQ-012 SHALL have port o_bit_count  output  32  saturating count of bits checked while LOCKED.

Function
REQ-013 SHALL accept a bit only on a clock edge where i_enable and i_enb_rx are both high; otherwise all state SHALL hold.
REQ-014 SHALL implement PRBS9, polynomial x^9+x^5+1: 9-bit register sr; next bit = sr[8] XOR sr[4]; shift left, inserting the new bit at sr[0].
REQ-015 SHALL implement states SEARCH, VERIFY and LOCKED.
REQ-016 SEARCH: each accepted i_bit is shifted into sr; after 9 accepted bits, go to VERIFY if sr is non-zero; if sr is all-zero, restart the 9-bit fill.
REQ-017 VERIFY/LOCKED: the expected bit is sr[8]^sr[4]; sr shifts in the expected bit, not i_bit (free-running local generator).
REQ-018 VERIFY: a match increments the match counter; after LOCK_THR consecutive matches, go to LOCKED; any mismatch returns to SEARCH with the fill counter cleared; no o_err pulse and no count change.
REQ-019 LOCKED: a mismatch pulses o_err on the next cycle and increments o_err_count, saturating at 16'hFFFF.
REQ-020 LOCKED: every accepted bit increments o_bit_count, saturating at 32'hFFFFFFFF.
REQ-021 LOCKED: the window counter wraps every WIN_LEN accepted bits and clears the window error counter on wrap; the bit that completes a window counts in the old window.
REQ-022 All outputs SHALL be registered; o_lock rises on the edge after the LOCK_THR-th match, i.e. 9+LOCK_THR accepted bits after reset for a clean stream.
REQ-023 A mismatch on the same edge as a window wrap SHALL count in the ending window before the clear.

Reset
REQ-024 When i_reset is low at an edge, state SHALL become SEARCH; sr, fill, match, window and error counters SHALL clear to 0; o_lock=0, o_err=0, o_err_count=0, o_bit_count=0.
REQ-025 Reset mid-LOCKED SHALL take full effect on that edge; reacquisition SHALL start from an empty fill.

Configuration
REQ-026 Macro PRBS_CHK_RELOCK_EN: when defined, reaching ERR_THR errors within one window in LOCKED SHALL return to SEARCH, with o_lock falling on the same edge; counters SHALL be retained.
REQ-027 Without PRBS_CHK_RELOCK_EN, LOCKED SHALL be sticky until reset, and the window logic SHALL be omitted.

Structure
REQ-028 Package prbs_pkg SHALL hold the PRBS9 width (9), tap indices (8, 4), the state enumeration typedef and the counter widths.
REQ-029 The next-bit/shift function SHALL be a sub-module, prbs9_step, shareable with the transmitter generator.

Verification
REQ-030 Feed the PRBS9 generator output (seed 9'h1AA, MSB-first: 1,1,0,1,0,1,0,1,0,...) with enables high -> o_lock=1 after 25 accepted bits; o_err_count=0 after 1000 bits.
REQ-031 While locked, invert one bit -> exactly one o_err pulse; o_err_count=1; o_lock stays 1.
REQ-032 With the macro defined, invert 8 bits within one 64-bit window -> o_lock=0 on the 8th error edge, then relock 25 bits later; without the macro, o_lock stays 1.
REQ-033 Constant i_bit=0 for 200 bits -> o_lock stays 0, state stays SEARCH, counts stay 0.
REQ-034 Toggle i_enb_rx low for 10 cycles mid-stream with the generator also paused -> no errors; o_bit_count stalls.
REQ-035 Assert i_reset low for one cycle while locked -> all outputs read 0 on the next cycle; relock after 25 bits.
